cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - nibble-serial adder sequencing one shared 4-bit carry-lookahead adder
//
// cla_4bit     : combinational 4-bit carry-lookahead adder (a + b + cin).
// cla_seq_ctrl : accepts one operation, adds it one nibble per clock (LSB nibble first)
//                through a single cla_4bit, then holds the result until it is consumed.
//
// Optional feature macro: CLA_SEQ_SUBTRACT_EN adds the 'sub' input (a - b - cin).
//
// Ports (cla_seq_ctrl):
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready only in IDLE)
//   a, b, cin            operands and carry-in (borrow-in when subtracting)
//   sub                  subtract select, only with CLA_SEQ_SUBTRACT_EN
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   sum, cout            registered result and final carry-out
//   busy                 high in RUN or DONE

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat generate/propagate expression of cin, no ripple.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
endmodule

module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             sub_w;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_cout;

`ifdef CLA_SEQ_SUBTRACT_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Current nibble of the captured operands.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    cla_4bit u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + ~cin, so b and the carry are
                    // inverted once at capture and the datapath only ever adds.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub_w}};
                    carry_d = cin ^ sub_w;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[4*i +: 4] = nib_sum;
                    end
                end
                carry_d = nib_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = nib_cout;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - self-checking bench for cla_seq_ctrl (WIDTH=16)

module tb_cla_seq_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUBTRACT_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic         vs;
        logic [W-1:0] es;
        logic         ec;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic logic [W:0] model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                         input logic vc, input logic vs);
        longint r;
        if (vs) begin
            r = longint'(va) - longint'(vb) - longint'(vc);
            return {(r >= 0), W'(r)};
        end
        r = longint'(va) + longint'(vb) + longint'(vc);
        return {(r >= (longint'(1) << W)), W'(r)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, check latency and in_ready, hold under
    // back-pressure with ignored in_valid pulses, consume, check IDLE state.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input logic vs, input int hold,
                          output logic [W-1:0] rs, output logic rc);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("ready_before_accept", in_ready, 1);
        a = va; b = vb; cin = vc; sub_r = vs; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_r = 1'($urandom);
        t = 0;
        while (!out_valid && t < 20) begin
            chk("in_ready_low_run", in_ready, 0);
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom);
            tick();
            t++;
        end
        in_valid = 1'b0;
        chk("latency", t, 4);
        rs = sum;
        rc = cout;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            tick();
            chk("hold_sum", sum, rs);
            chk("hold_cout", cout, rc);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ready_after_consume", in_ready, 1);
        chk("valid_after_consume", out_valid, 0);
        chk("idle_sum_kept", sum, rs);
        chk("idle_cout_kept", cout, rc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        logic [W:0]   m;
        logic [W:0]   exp_q[$];
        int           last_acc;
        int           t;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;

        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 5});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 0});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0});
        vecs.push_back('{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 3});
`ifdef CLA_SEQ_SUBTRACT_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0});
`endif

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vs, vecs[i].hold, rs, rc);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].es);
            chk($sformatf("vec%0d_cout", i), rc, vecs[i].ec);
        end

        // Reset on the second RUN cycle abandons the operation
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("run_busy", busy, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_sum", sum, 0);
        chk("midrun_rst_cout", cout, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, rs, rc);
        chk("post_rst_sum", rs, 16'h0100);
        chk("post_rst_cout", rc, 0);

        // Reset wins over a consume handshake in DONE
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk("prio_reached_done", out_valid, 1);
        out_ready = 1'b1; rst = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("prio_sum", sum, 0);
        chk("prio_cout", cout, 0);
        chk("prio_in_ready", in_ready, 1);

        // Randomized operations against the model
        for (int k = 0; k < 150; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rci;
            logic         rsub;
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
`ifdef CLA_SEQ_SUBTRACT_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            if (k % 5 == 0) ra = '1;
            m = model(ra, rb, rci, rsub);
            run_op(ra, rb, rci, rsub, int'($urandom_range(0, 3)), rs, rc);
            chk($sformatf("rand%0d_sum", k), rs, m[W-1:0]);
            chk($sformatf("rand%0d_cout", k), rc, m[W]);
        end

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sub_r     = 1'b0;
        last_acc  = -1;
        for (int c = 0; c < 62; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected_result", 1, 0);
                end else begin
                    m = exp_q.pop_front();
                    chk("b2b_sum", sum, m[W-1:0]);
                    chk("b2b_cout", cout, m[W]);
                end
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (in_ready) begin
                exp_q.push_back(model(a, b, cin, 1'b0));
                if (last_acc >= 0) chk("b2b_interval", c - last_acc, 6);
                last_acc = c;
            end
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && exp_q.size() != 0) begin
                m = exp_q.pop_front();
                chk("b2b_drain_sum", sum, m[W-1:0]);
                chk("b2b_drain_cout", cout, m[W]);
            end
            tick();
        end
        out_ready = 1'b0;
        chk("b2b_all_results", exp_q.size(), 0);
        chk("b2b_idle", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
